// File: rtl/mat_axis_in_fifo_if.sv
// AXI-Stream bundle (tdata/tvalid/tlast/tready) shared by the input FIFO ports.
// The master drives data/valid/last. The slave drives ready.
interface mat_axis_in_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/mat_axis_in_fifo.sv
// Input-side AXI-Stream buffer in front of mat_mul.
// - A circular FIFO absorbs upstream bursts. Its output is first-word fall-through.
// - tlast is regenerated so that every SIZE-th pushed word closes a matrix frame.
// - With MAT_FRAME_CHECK_EN defined, an upstream tlast that disagrees with the matrix
//   boundary sets a sticky frame_err. clear_err clears it. Data always passes through.
module mat_axis_in_fifo #(
    parameter int unsigned DIM_LOG        = 1,
    parameter int unsigned DIM            = 2 ** DIM_LOG,
    parameter int unsigned SIZE           = DIM * DIM,
    parameter int unsigned SIZE_LOG       = 2 * DIM_LOG,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH_LOG = 3
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    mat_axis_in_fifo_if.slave         s00_axis,
    mat_axis_in_fifo_if.master        m00_axis,
    input  logic                      clear_err,
    output logic                      frame_err,
    output logic [FIFO_DEPTH_LOG:0]   level
);

    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] LevelFull = (FIFO_DEPTH_LOG + 1)'(Depth);
    localparam logic [SIZE_LOG-1:0] FrameLast = SIZE_LOG'(SIZE - 1);

    // Each entry holds {regenerated last, data}
    logic [DATA_WIDTH:0]       mem [Depth];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG:0]   level_q, level_d;
    logic [SIZE_LOG-1:0]       frame_cnt_q, frame_cnt_d;

    logic full, empty, push, pop, frame_end;
    logic [DATA_WIDTH:0] rd_word;

    // Handshake decode, all derived from the registered occupancy
    always_comb begin
        full      = (level_q == LevelFull);
        empty     = (level_q == '0);
        push      = s00_axis.tvalid & ~full;
        pop       = m00_axis.tready & ~empty;
        frame_end = (frame_cnt_q == FrameLast);
    end

    assign s00_axis.tready = ~full;
    assign m00_axis.tvalid = ~empty;
    assign level           = level_q;

    // Fall-through read of the head entry. tlast is gated so it reads 0 while empty.
    always_comb begin
        rd_word        = mem[rd_ptr_q];
        m00_axis.tdata = rd_word[DATA_WIDTH-1:0];
        m00_axis.tlast = rd_word[DATA_WIDTH] & ~empty;
    end

    // Storage array, not reset: stale contents are never visible because of level
    always_ff @(posedge s00_axi_aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= {frame_end, s00_axis.tdata};
        end
    end

    // Next state for the pointers, the occupancy and the frame position
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        if (push) begin
            wr_ptr_d    = wr_ptr_q + FIFO_DEPTH_LOG'(1);
            frame_cnt_d = frame_end ? '0 : frame_cnt_q + SIZE_LOG'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_DEPTH_LOG + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_DEPTH_LOG + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO control state registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef MAT_FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;

    // Sticky boundary-mismatch flag. A new mismatch wins over a same-cycle clear.
    always_comb begin
        frame_err_d = frame_err_q;
        if (push && (s00_axis.tlast != frame_end)) begin
            frame_err_d = 1'b1;
        end else if (clear_err) begin
            frame_err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    // Checker absent: upstream tlast and clear_err are intentionally ignored
    logic unused_check_inputs;
    assign unused_check_inputs = s00_axis.tlast ^ clear_err;
    assign frame_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mat_axis_in_fifo.sv
// Self-checking bench for mat_axis_in_fifo (DIM_LOG = 1, depth 8).
// A scoreboard queue receives each accepted input word together with its expected
// regenerated tlast. The queue is popped and compared on every output handshake.
module tb_mat_axis_in_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned DL = 3;

`ifdef MAT_FRAME_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_err = 1'b0;
    logic          frame_err;
    logic [DL:0]   level;

    mat_axis_in_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    mat_axis_in_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    mat_axis_in_fifo #(
        .DIM_LOG        (1),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH_LOG (DL)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axis        (s_if),
        .m00_axis        (m_if),
        .clear_err       (clear_err),
        .frame_err       (frame_err),
        .level           (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } sb_t;

    sb_t           sb[$];
    int            mcnt = 0;
    logic          chk_lat = 1'b0;
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            sb.delete();
            mcnt   = 0;
            held_v = 1'b0;
        end else begin
            if (held_v && m_if.tvalid) begin
                check_eq("hold_data", m_if.tdata, held_d);
                check_eq("hold_last", m_if.tlast, held_l);
            end
            held_v = m_if.tvalid && !m_if.tready;
            held_d = m_if.tdata;
            held_l = m_if.tlast;
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", m_if.tvalid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_data", m_if.tdata, e.d);
                    check_eq("out_last", m_if.tlast, e.l);
                    if (chk_lat) check_eq("latency", cyc - e.c, 1);
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                e.d = s_if.tdata;
                e.l = (mcnt == 3);
                e.c = cyc;
                sb.push_back(e);
                mcnt = (mcnt + 1) % 4;
            end
        end
    end

    int sent_cnt = 0;

    function automatic logic good_last();
        return (sent_cnt % 4) == 3;
    endfunction

    // Present one word and hold it until accepted; returns at posedge+1
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check_eq("send_timeout", ok, 1'b1);
        s_if.tvalid = 1'b0;
        sent_cnt++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || level != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, level, 0);
    endtask

    logic bp_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle
        check_eq("rst_s_tready", s_if.tready, 1'b1);
        check_eq("rst_m_tvalid", m_if.tvalid, 1'b0);
        check_eq("rst_m_tlast", m_if.tlast, 1'b0);
        check_eq("rst_level", level, 0);
        check_eq("rst_frame_err", frame_err, 1'b0);

        // Streaming: 8 words back-to-back with the sink always ready
        m_if.tready = 1'b1;
        chk_lat = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i), good_last());
        drain("stream_drain");
        chk_lat = 1'b0;

        // Fill: the sink is stalled, so only 8 words fit
        m_if.tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(i), good_last());
        check_eq("fill_level", level, 8);
        check_eq("fill_s_tready", s_if.tready, 1'b0);
        s_if.tdata  = 32'd9;
        s_if.tlast  = good_last();
        s_if.tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("full_no_push", level, 8);
        m_if.tready = 1'b1;
        send(32'd9, good_last());
        send(32'd10, good_last());
        drain("fill_drain");

        // Backpressure: the sink toggles ready every cycle while 10 words stream in
        bp_done = 1'b0;
        fork
            begin
                for (int i = 1; i <= 10; i++) send(DW'(100 + i), good_last());
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    m_if.tready = ~m_if.tready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_if.tready = 1'b1;
        drain("bp_drain");
        check_eq("no_err_yet", frame_err, 1'b0);

        // Frame check: upstream tlast lands on word 3 of the frame instead of word 4
        send(32'd201, good_last());
        send(32'd202, good_last());
        check_eq("err_before", frame_err, 1'b0);
        send(32'd203, 1'b1);
        check_eq("err_rise", frame_err, ERR_EXP);
        send(32'd204, 1'b0);
        check_eq("err_sticky", frame_err, ERR_EXP);
        drain("frame_drain");
        check_eq("err_idle", frame_err, ERR_EXP);
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        check_eq("err_clear", frame_err, 1'b0);

        // Async reset mid-frame with 5 words buffered
        m_if.tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(DW'(300 + i), good_last());
        check_eq("pre_rst_level", level, 5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_s_tready", s_if.tready, 1'b1);
        check_eq("arst_m_tvalid", m_if.tvalid, 1'b0);
        check_eq("arst_m_tlast", m_if.tlast, 1'b0);
        check_eq("arst_level", level, 0);
        check_eq("arst_frame_err", frame_err, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        sent_cnt = 0;
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(400 + i), good_last());
        drain("post_rst_drain");

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_axis_in_fifo.md
# mat_axis_in_fifo

Input-side AXI-Stream buffer that sits directly upstream of the matrix-multiply accelerator's slave stream port, between the DMA stream output and `mat_mul`. It absorbs upstream bursts in a small circular FIFO, regenerates `tlast` so every SIZE-th word closes one matrix frame, and optionally flags upstream frames whose `tlast` does not land on a matrix boundary.

## Interface
- `DIM_LOG`, 1, matrix dimension in log2
- `DIM`, 2**DIM_LOG, matrix dimension
- `SIZE`, DIM*DIM, words per matrix frame
- `SIZE_LOG`, 2*DIM_LOG, frame counter width
- `DATA_WIDTH`, 32, stream word width
- `FIFO_DEPTH_LOG`, 3, FIFO depth in log2 (depth = 2**FIFO_DEPTH_LOG)

- `s00_axi_aclk` in 1: single clock.
- `s00_axi_aresetn` in 1: reset, asynchronous, active-low.
- `s00_axis_tdata` in DATA_WIDTH: upstream data.
- `s00_axis_tvalid` in 1: upstream valid.
- `s00_axis_tlast` in 1: upstream last, checked only.
- `s00_axis_tready` out 1: FIFO not full.
- `m00_axis_tdata` out DATA_WIDTH: data to `mat_mul`.
- `m00_axis_tvalid` out 1: FIFO not empty.
- `m00_axis_tlast` out 1: regenerated frame end.
- `m00_axis_tready` in 1: `mat_mul` ready.
- `clear_err` in 1: synchronous clear of `frame_err`.
- `frame_err` out 1: sticky boundary-mismatch flag.
- `level` out FIFO_DEPTH_LOG+1: current occupancy.

## Operation
- Storage: 2**FIFO_DEPTH_LOG entries of {last, data}; write pointer, read pointer, and occupancy counter, all with wrap-around at depth.
- Push = `s00_axis_tvalid & s00_axis_tready`; pop = `m00_axis_tvalid & m00_axis_tready`.
- `s00_axis_tready` = (level != depth); `m00_axis_tvalid` = (level != 0). Both are combinational from `level`, which is a register.
- Full: `tready` = 0, and no push occurs even if a pop happens the same cycle. Empty: `tvalid` = 0, and pop is impossible.
- Simultaneous push and pop when neither full nor empty: both pointers advance and `level` is unchanged.
- Output is first-word fall-through: `m00_axis_tdata`/`tlast` come from the entry at the read pointer. They are stable while `tvalid` = 1 and `tready` = 0.
- Frame counter (SIZE_LOG bits) increments on each push and wraps from SIZE-1 to 0. The stored last bit is (counter == SIZE-1).
- Consecutive frames need no gap: frame A, then frame B, then the next A, and so on. The block does not track which matrix is which.
- Error check (macro-enabled): on a push, a mismatch between `s00_axis_tlast` and (counter == SIZE-1) sets `frame_err`. The counter is not resynchronised. Data is always passed through.
- `clear_err` clears `frame_err` on the next edge. If a mismatch occurs in the same cycle as `clear_err`, set takes priority.
- Reset mid-operation: pointers, `level`, frame counter and `frame_err` are all cleared, and buffered words are discarded.

## Timing
- Reset values: `s00_axis_tready` = 1, `m00_axis_tvalid` = 0, `m00_axis_tlast` = 0, `m00_axis_tdata` = don't-care (the bench must not check it), `frame_err` = 0, `level` = 0.
- Latency: a word pushed at edge N is visible with `m00_axis_tvalid` = 1 after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle sustained when both sides are continuously ready.
- `frame_err` is registered and goes high one cycle after the offending push.
- `level` updates on every edge with push/pop.

## Configuration
- `MAT_FRAME_CHECK_EN` defined: the tlast comparison and sticky `frame_err` are implemented, and `clear_err` is honoured.
- Undefined: `frame_err` is tied to 0, and `s00_axis_tlast` and `clear_err` are ignored. FIFO and tlast regeneration behave identically in both cases.

## Test plan
- Reset then idle: check `s00_axis_tready` = 1, `m00_axis_tvalid` = 0, `level` = 0, `frame_err` = 0.
- Streaming: DIM_LOG = 1, `m00_axis_tready` = 1, push 8 words 1..8 back-to-back. Output must be 1..8, one per cycle, each one cycle after input, with `m00_axis_tlast` high on words 4 and 8.
- Fill: `m00_axis_tready` = 0, push 10 words. `tready` must drop after 8 accepted words and `level` must reach 8. Release `tready` and words 1..8 must drain in order.
- Backpressure: toggle `m00_axis_tready` 1,0,1,0 during output. Data must hold while stalled, with no loss or duplication.
- Frame check (macro on): upstream `tlast` on word 3. `frame_err` must rise the next cycle and stay set through word 4. Pulse `clear_err` and it must return to 0. With the macro off, `frame_err` must stay 0.
- Async reset: assert `s00_axi_aresetn` mid-frame with `level` = 5. Outputs must be at reset values immediately. After release, a fresh 4-word frame must end with `tlast` on its 4th word.
